// File: rtl/riscv_pkg.sv
// Shared core package: writeback entry layout and default sizing used by the
// writeback arbiter, the register file and the hazard unit.
package riscv_pkg;

   localparam int WB_DATA_WIDTH    = 32;
   localparam int WB_ADDRESS_WIDTH = 5;
   localparam int WB_FIFO_DEPTH    = 4;
   localparam int WB_STARVE_MAX    = 3;

   // One buffered writeback result: destination register and its value.
   typedef struct packed {
      logic [WB_ADDRESS_WIDTH-1:0] rd;
      logic [WB_DATA_WIDTH-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO for auxiliary writeback results. Besides the head
// it exposes the tag field (top TAG_WIDTH bits) of every slot plus a per-slot
// valid mask, so the owner can build a bitmap of in-flight destinations.
module wb_fifo
   import riscv_pkg::*;
#(
   parameter int WIDTH     = WB_ADDRESS_WIDTH + WB_DATA_WIDTH,
   parameter int TAG_WIDTH = WB_ADDRESS_WIDTH,
   parameter int DEPTH     = WB_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic [TAG_WIDTH-1:0]     entries [DEPTH],
   output logic [DEPTH-1:0]         entry_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2**PW).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage array; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Head read, tag export and slot-valid mask (slot live if its distance from rd_ptr < count).
   always_comb begin
      dout = mem[rd_ptr];
      for (int i = 0; i < DEPTH; i++) begin
         entries[i]     = mem[i][WIDTH-1 -: TAG_WIDTH];
         entry_valid[i] = {1'b0, PW'(i) - rd_ptr} < count;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port. The
// in-order pipeline normally wins; long-latency aux results wait in a small
// FIFO and are forced through after STARVE_MAX consecutive pipeline wins.
module wb_arbiter
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH    = WB_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
   parameter int FIFO_DEPTH    = WB_FIFO_DEPTH,
   parameter int STARVE_MAX    = WB_STARVE_MAX
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           pipe_valid,
   output logic                           pipe_ready,
   input  logic [ADDRESS_WIDTH-1:0]       pipe_rd,
   input  logic [DATA_WIDTH-1:0]          pipe_data,
   input  logic                           aux_valid,
   output logic                           aux_ready,
   input  logic [ADDRESS_WIDTH-1:0]       aux_rd,
   input  logic [DATA_WIDTH-1:0]          aux_data,
   output logic                           rf_we,
   output logic [ADDRESS_WIDTH-1:0]       rf_addr,
   output logic [DATA_WIDTH-1:0]          rf_wdata,
   output logic [2**ADDRESS_WIDTH-1:0]    aux_pending,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int EW = ADDRESS_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   logic [SW-1:0]            starve_cnt;
   logic                     force_aux;
   logic                     grant_pipe;
   logic                     grant_aux;
   logic                     push;
   logic [EW-1:0]            head;
   logic [ADDRESS_WIDTH-1:0] entries [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]    entry_valid;

   wb_fifo #(
      .WIDTH     (EW),
      .TAG_WIDTH (ADDRESS_WIDTH),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .pop         (grant_aux),
      .din         ({aux_rd, aux_data}),
      .dout        (head),
      .count       (fifo_count),
      .entries     (entries),
      .entry_valid (entry_valid)
   );

   // Handshake readiness and grants. aux_ready looks only at the count, so a
   // full FIFO refuses input even on a cycle where it also pops.
   always_comb begin
      force_aux  = (fifo_count != '0) && (starve_cnt == STARVE_C);
      pipe_ready = !force_aux;
      aux_ready  = fifo_count < DEPTH_C;
      grant_pipe = pipe_valid && pipe_ready;
      grant_aux  = (fifo_count != '0) && (!pipe_valid || force_aux);
      push       = aux_valid && aux_ready && (aux_rd != '0);
   end

   // Count consecutive pipeline wins over a waiting aux entry, saturating at STARVE_MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if ((fifo_count == '0) || grant_aux) begin
         starve_cnt <= '0;
      end else if (grant_pipe && (starve_cnt != STARVE_C)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Registered register-file write port; address/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_wdata <= '0;
      end else if (grant_pipe) begin
         rf_we    <= (pipe_rd != '0);
         rf_addr  <= pipe_rd;
         rf_wdata <= pipe_data;
      end else if (grant_aux) begin
         rf_we    <= 1'b1;
         rf_addr  <= head[EW-1:DATA_WIDTH];
         rf_wdata <= head[DATA_WIDTH-1:0];
      end else begin
         rf_we    <= 1'b0;
      end
   end

   // Pending bitmap: one bit per destination held in a live FIFO slot; x0 never pends.
   always_comb begin
      aux_pending = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i]) aux_pending[entries[i]] = 1'b1;
      end
      aux_pending[0] = 1'b0;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;

   localparam int DEPTH  = 4;
   localparam int STARVE = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        pipe_valid = 1'b0;
   logic        pipe_ready;
   logic [4:0]  pipe_rd = '0;
   logic [31:0] pipe_data = '0;
   logic        aux_valid = 1'b0;
   logic        aux_ready;
   logic [4:0]  aux_rd = '0;
   logic [31:0] aux_data = '0;
   logic        rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [31:0] aux_pending;
   logic [2:0]  fifo_count;

   wb_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pipe_valid  (pipe_valid),
      .pipe_ready  (pipe_ready),
      .pipe_rd     (pipe_rd),
      .pipe_data   (pipe_data),
      .aux_valid   (aux_valid),
      .aux_ready   (aux_ready),
      .aux_rd      (aux_rd),
      .aux_data    (aux_data),
      .rf_we       (rf_we),
      .rf_addr     (rf_addr),
      .rf_wdata    (rf_wdata),
      .aux_pending (aux_pending),
      .fifo_count  (fifo_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_sc = 0;
   logic        m_we = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   logic        m_pipe_xfer = 1'b0;
   logic        m_aux_xfer = 1'b0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin : model
      if (!rst_n) begin
         mq.delete();
         m_sc        <= 0;
         m_we        <= 1'b0;
         m_addr      <= '0;
         m_data      <= '0;
         m_pipe_xfer <= 1'b0;
         m_aux_xfer  <= 1'b0;
      end else begin
         automatic int cnt = mq.size();
         automatic bit frc = (cnt != 0) && (m_sc == STARVE);
         automatic bit gp  = pipe_valid && !frc;
         automatic bit ga  = (cnt != 0) && (!pipe_valid || frc);
         automatic bit ax  = aux_valid && (cnt < DEPTH);
         if (gp) begin
            m_we   <= (pipe_rd != 0);
            m_addr <= pipe_rd;
            m_data <= pipe_data;
         end else if (ga) begin
            m_we   <= 1'b1;
            m_addr <= mq[0].rd;
            m_data <= mq[0].data;
            void'(mq.pop_front());
         end else begin
            m_we <= 1'b0;
         end
         if (cnt == 0 || ga) m_sc <= 0;
         else if (gp && m_sc < STARVE) m_sc <= m_sc + 1;
         if (ax && aux_rd != 0) mq.push_back('{aux_rd, aux_data});
         m_pipe_xfer <= gp;
         m_aux_xfer  <= ax;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      automatic logic [31:0] pend = '0;
      foreach (mq[i]) pend[mq[i].rd] = 1'b1;
      check("rf_we", rf_we, m_we);
      check("rf_addr", rf_addr, m_addr);
      check("rf_wdata", rf_wdata, m_data);
      check("fifo_count", fifo_count, mq.size());
      check("aux_pending", aux_pending, pend);
      check("aux_ready", aux_ready, mq.size() < DEPTH);
      check("pipe_ready", pipe_ready, !(mq.size() != 0 && m_sc == STARVE));
   end

   // Record aux-sourced writes (rd 1..15) during the fill scenario
   logic       mon_on = 1'b0;
   int         aux_addr_q[$];
   int         aux_cyc_q[$];
   always @(negedge clk) begin
      if (mon_on && rf_we && rf_addr != 0 && rf_addr < 16) begin
         aux_addr_q.push_back(int'(rf_addr));
         aux_cyc_q.push_back(cyc);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      // Reset held with both channels offering
      #1;
      rst_n      = 1'b0;
      pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h4444_4444;
      aux_valid  = 1'b1; aux_rd  = 5'd3; aux_data  = 32'h3333_3333;
      repeat (3) @(negedge clk);
      check("rst_rf_we", rf_we, 0);
      check("rst_fifo_count", fifo_count, 0);
      check("rst_aux_pending", aux_pending, 0);
      #1;
      pipe_valid = 1'b0; aux_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk); #1;

      // Pipeline write, then rd=0 write suppressed
      pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("pipe_we", rf_we, 1);
      check("pipe_addr", rf_addr, 5);
      check("pipe_data", rf_wdata, 32'hDEAD_BEEF);
      #1;
      pipe_rd = 5'd0; pipe_data = 32'h0000_0001;
      @(negedge clk);
      check("pipe_rd0_we", rf_we, 0);
      #1;
      pipe_valid = 1'b0;

      // Aux write: pending next cycle, write two edges after transfer
      aux_valid = 1'b1; aux_rd = 5'd7; aux_data = 32'h1234_5678;
      @(negedge clk);
      check("aux_pend7_set", aux_pending[7], 1);
      check("aux_early_we", rf_we, 0);
      #1;
      aux_valid = 1'b0;
      @(negedge clk);
      check("aux_we", rf_we, 1);
      check("aux_addr", rf_addr, 7);
      check("aux_data", rf_wdata, 32'h1234_5678);
      check("aux_pend7_clr", aux_pending[7], 0);
      #1;

      // Fill with pipeline continuously valid; forced aux every 4th cycle
      mon_on     = 1'b1;
      pipe_valid = 1'b1; pipe_rd = 5'd20; pipe_data = 32'hA5A5_0000;
      k = 1;
      aux_valid = 1'b1; aux_rd = 5'(k); aux_data = 32'h1000_0000 + k;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c == 3) begin
            check("fill_count4", fifo_count, 4);
            check("fill_aux_ready0", aux_ready, 0);
            check("fill_pipe_ready0", pipe_ready, 0);
         end
         if (c == 4) begin
            check("full_pop_we", rf_we, 1);
            check("full_pop_addr", rf_addr, 1);
            check("full_pop_count", fifo_count, 3);
            check("full_pop_aux_ready", aux_ready, 1);
         end
         if (c == 5) check("refill_count4", fifo_count, 4);
         #1;
         if (aux_valid && m_aux_xfer) begin
            k++;
            if (k > 5) aux_valid = 1'b0;
            else begin
               aux_rd = 5'(k); aux_data = 32'h1000_0000 + k;
            end
         end
      end
      pipe_valid = 1'b0;
      mon_on     = 1'b0;
      check("fill_n_aux", aux_addr_q.size(), 5);
      for (int i = 0; i < aux_addr_q.size(); i++) begin
         check("fill_order", aux_addr_q[i], i + 1);
         if (i > 0) check("fill_gap", aux_cyc_q[i] - aux_cyc_q[i-1], 4);
      end

      // Reset mid-drain
      @(negedge clk); #1;
      pipe_valid = 1'b1; pipe_rd = 5'd21; pipe_data = 32'h2121_2121;
      k = 9;
      aux_valid = 1'b1; aux_rd = 5'(k); aux_data = 32'h9000_0000 + k;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); #1;
         if (m_aux_xfer) begin
            k++;
            aux_rd = 5'(k); aux_data = 32'h9000_0000 + k;
         end
      end
      aux_valid = 1'b0; pipe_valid = 1'b0;
      @(negedge clk);
      check("drain_we", rf_we, 1);
      check("drain_addr", rf_addr, 9);
      check("drain_count", fifo_count, 2);
      check("drain_pend10", aux_pending[10], 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_we", rf_we, 0);
      check("midrst_addr", rf_addr, 0);
      check("midrst_count", fifo_count, 0);
      check("midrst_pending", aux_pending, 0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("post_rst_we", rf_we, 0);
         check("post_rst_pending", aux_pending, 0);
      end
      #1;

      // Randomized traffic obeying the hold-until-accepted rule
      for (int i = 0; i < 800; i++) begin
         automatic int aux_pct = (i < 400) ? 70 : 30;
         if (!pipe_valid || m_pipe_xfer) begin
            pipe_valid = ($urandom_range(0, 99) < 60);
            pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_data  = $urandom;
         end
         if (!aux_valid || m_aux_xfer) begin
            aux_valid = ($urandom_range(0, 99) < aux_pct);
            aux_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            aux_data  = $urandom;
         end
         @(negedge clk); #1;
      end
      pipe_valid = 1'b0; aux_valid = 1'b0;
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
